// File: rtl/adffe_reg_pkg.sv
// Shared constants and word type for the enabled data register.
// The default width and reset value are the ones a plain 32-bit datapath word uses.
package adffe_reg_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

  localparam word_t DEFAULT_RESET_VALUE = '0;

endpackage

// File: rtl/adffe_reg_bit.sv
// Single-bit storage cell: reset beats enable, enable beats hold.
// One edge of latency, no handshake; INIT gives the power-up value of the flop.
module adffe_reg_bit
  import adffe_reg_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic d,
  input  logic rst_val,
  output logic q
);

  // Declaration initialiser gives a defined power-up value even if reset is never sampled.
  logic q_q = INIT;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (rst_i) begin
      q_d = rst_val;
    end else if (en_i) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/adffe_reg.sv
// WIDTH-bit data register with clock enable and synchronous active-high reset.
// One edge of capture latency, no handshake; q_o comes straight from the flops.
module adffe_reg
  import adffe_reg_pkg::*;
#(
  parameter int                 WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] q_o
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("adffe_reg: WIDTH must be in 1..64");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    adffe_reg_bit #(
      .INIT(RESET_VALUE[i])
    ) u_bit (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (en_i),
      .d      (data_i[i]),
      .rst_val(RESET_VALUE[i]),
      .q      (q_o[i])
    );
  end

endmodule

// File: tb/tb_adffe_reg.sv
// Bench for adffe_reg: 32-bit default instance and an 8-bit instance with reset value 0x5A,
// directed vectors with literal expectations plus a cycle-by-cycle reference model.
module tb_adffe_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [31:0] data_i;
  logic [7:0]  data8;
  logic [31:0] q32;
  logic [7:0]  q8;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference state: what each register must hold after the most recent edge.
  logic [31:0] m32 = 32'h0000_0000;
  logic [7:0]  m8  = 8'h5A;

  assign data8 = data_i[7:0];

  always #5 clk_i = ~clk_i;

  adffe_reg u_dut32 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en_i),
    .data_i(data_i),
    .q_o   (q32)
  );

  adffe_reg #(
    .WIDTH      (8),
    .RESET_VALUE(8'h5A)
  ) u_dut8 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en_i),
    .data_i(data8),
    .q_o   (q8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk_i) begin
    if (rst_i) begin
      m32 = 32'h0000_0000;
      m8  = 8'h5A;
    end else if (en_i) begin
      m32 = data_i;
      m8  = data_i[7:0];
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("model32", {32'h0, q32}, {32'h0, m32});
      check("model8",  {56'h0, q8},  {56'h0, m8});
    end
  end

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i  = 1'b0;
    en_i   = 1'b0;
    data_i = 32'h0;
    #1;
    check("powerup32", {32'h0, q32}, 64'h0000_0000);
    check("powerup8",  {56'h0, q8},  64'h5A);
    chk_en = 1'b1;
    @(negedge clk_i);

    en_i = 1'b1; data_i = 32'h1234_5678;
    step();
    check("capture32", {32'h0, q32}, 64'h1234_5678);
    check("capture8",  {56'h0, q8},  64'h78);

    en_i = 1'b0; data_i = 32'hFFFF_FFFF;
    step();
    step();
    check("hold32", {32'h0, q32}, 64'h1234_5678);
    check("hold8",  {56'h0, q8},  64'h78);

    en_i = 1'b1; data_i = 32'hDEAD_BEEF;
    step();
    check("load_deadbeef", {32'h0, q32}, 64'hDEAD_BEEF);
    rst_i = 1'b1; en_i = 1'b1; data_i = 32'hCAFE_F00D;
    step();
    check("rst_prio32", {32'h0, q32}, 64'h0000_0000);
    check("rst_prio8",  {56'h0, q8},  64'h5A);
    rst_i = 1'b0;

    en_i = 1'b1; data_i = 32'hA5A5_A5A5;
    step();
    check("load_a5", {32'h0, q32}, 64'hA5A5_A5A5);
    // Reset and enable both glitch high only between edges.
    en_i = 1'b0; data_i = 32'h0;
    #1 rst_i = 1'b1; en_i = 1'b1;
    #2 rst_i = 1'b0; en_i = 1'b0;
    step();
    check("sync_rst32", {32'h0, q32}, 64'hA5A5_A5A5);
    check("sync_rst8",  {56'h0, q8},  64'hA5);

    rst_i = 1'b1; en_i = 1'b0;
    step();
    check("rst_noen32", {32'h0, q32}, 64'h0000_0000);
    check("rst_noen8",  {56'h0, q8},  64'h5A);
    rst_i = 1'b0;

    void'($urandom(123));
    for (int i = 0; i < 1000; i++) begin
      rst_i  = ($urandom_range(0, 7) == 0);
      en_i   = 1'($urandom_range(0, 1));
      data_i = $urandom;
      step();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
